uart_tx_ctrl: RTL and testbench

UART transmit controller that drains the UART FIFO written through the MMIO window and serialises each word onto a single `tx` line as an 8N1-style frame. It sits between the FIFO's read port and the board pin. It owns the FIFO read handshake so that CPU writes to the UART register are transmitted with no further software involvement.

---
 rtl/uart_tx_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//
// Purpose:
//   Drains the UART transmit FIFO and serialises each word onto the tx pin as
//   a start bit (0), DATA_WIDTH data bits sent LSB first, an optional
//   even-parity bit, and a stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
//   The controller owns the FIFO read handshake, so software only needs to
//   write words into the FIFO.
//
// Optional feature:
//   Define UART_TX_PARITY_EN to add a PARITY state between DATA and STOP.
//   That state drives the even-parity bit, which is the XOR of all data bits.
//   With the macro undefined, DATA goes straight to STOP and no parity logic
//   is built.
//
// Ports:
//   clk           - single clock; all state changes on its rising edge
//   rst           - asynchronous, active-low reset
//   enable        - permits a new frame to start; an in-flight frame always
//                   completes
//   fifo_data_out - FIFO read data, valid the cycle after fifo_read_en
//   fifo_empty    - FIFO empty flag
//   fifo_read_en  - FIFO pop strobe, high for the single FETCH cycle
//   tx            - registered serial output, idles high
//   busy          - high in every state except IDLE

module uart_tx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      baud_q,  baud_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic                  tx_q,    tx_d;
    logic                  baud_last;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // State register. The async reset drops tx high at once and discards any
    // word that has already been popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            baud_q   <= '0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        baud_d       = baud_q;
        idx_d        = idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        fifo_read_en = 1'b0;
        baud_last    = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                // The empty check keeps the strobe legal even if the FIFO
                // were drained by someone else between IDLE and FETCH.
                if (!fifo_empty) begin
                    fifo_read_en = 1'b1;
                    state_d      = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end

            LOAD: begin
                shift_d  = fifo_data_out;
                baud_d   = '0;
                idx_d    = '0;
`ifdef UART_TX_PARITY_EN
                // Latch parity now, because the shift register is consumed
                // by the time the parity bit is sent.
                parity_d = ^fifo_data_out;
`endif
                state_d  = START;
            end

            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif

            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered, so it is derived from the state being entered.
        // This makes the pin change on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DW + 3;
`else
    localparam int FRAME_BITS = DW + 2;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic          tx;
    logic          busy;

    // Simple FIFO model: pushes come from the stimulus thread, and pops come
    // from the DUT strobe. Read data is valid the cycle after the strobe.
    logic [DW-1:0] fifo_mem [64];
    int push_cnt = 0;
    int pop_cnt  = 0;
    assign fifo_empty = (push_cnt == pop_cnt);

    typedef struct {
        logic [DW-1:0] data;
        int            gap;   // required idle-high cycles before this frame, -1 = don't care
    } exp_t;
    exp_t exp_q[$];

    int checks      = 0;
    int passes      = 0;
    int frames_done = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .rst           (rst_n),
        .enable        (enable),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_read_en  (fifo_read_en),
        .tx            (tx),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_read_en) begin
            fifo_data_out <= fifo_mem[pop_cnt % 64];
            pop_cnt       <= pop_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    endtask

    task automatic push(input logic [DW-1:0] d, input int gap);
        exp_t e;
        fifo_mem[push_cnt % 64] = d;
        push_cnt++;
        e.data = d;
        e.gap  = gap;
        exp_q.push_back(e);
        $display("push 0x%02h", d);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_done", frames_done, target);
    endtask

    // Monitor: receives frames off tx and compares each one, cycle by cycle,
    // against the next scoreboard entry.
    task automatic monitor();
        bit in_frame = 0;
        bit post_frame = 0;
        bit wave_ok = 1;
        int cyc = 0;
        int gap_cnt = 0;
        logic [FRAME_BITS-1:0] exp_bits = '0;
        logic [FRAME_BITS-1:0] got_bits = '0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame   = 0;
                post_frame = 0;
                gap_cnt    = 0;
            end else begin
                if (fifo_read_en) chk("pop_when_empty", fifo_empty, 0);
                if (post_frame) begin
                    chk("busy_after_stop", busy, 0);
                    post_frame = 0;
                end
                if (!in_frame) begin
                    if (tx === 1'b0) begin
                        in_frame = 1;
                        cyc      = 0;
                        wave_ok  = 1;
                        got_bits = '0;
                        if (exp_q.size() == 0) begin
                            chk("frame_expected", exp_q.size(), 1);
                            cur.data = '0;
                            cur.gap  = -1;
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        if (cur.gap >= 0) chk("interframe_gap", gap_cnt, cur.gap);
                        exp_bits[0] = 1'b0;
                        for (int i = 0; i < DW; i++) exp_bits[1+i] = cur.data[i];
`ifdef UART_TX_PARITY_EN
                        exp_bits[DW+1] = ^cur.data;
`endif
                        exp_bits[FRAME_BITS-1] = 1'b1;
                    end else begin
                        gap_cnt++;
                    end
                end
                if (in_frame) begin
                    if (tx !== exp_bits[cyc/CPB]) wave_ok = 0;
                    if (cyc % CPB == CPB/2) got_bits[cyc/CPB] = tx;
                    cyc++;
                    if (cyc == FRAME_CYC) begin
                        checks++;
                        if (wave_ok) begin
                            passes++;
                            $display("frame 0x%02h bits %b", cur.data, got_bits);
                        end else begin
                            $display("FAIL frame_wave: got bits %b expected %b (data 0x%02h)",
                                     got_bits, exp_bits, cur.data);
                        end
                        in_frame   = 0;
                        gap_cnt    = 0;
                        post_frame = 1;
                        frames_done++;
                    end
                end
            end
        end
    endtask

    initial begin
        int pops0;
        int n;
        fork
            monitor();
        join_none

        // 1. Reset values, then idle with an empty FIFO.
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_read_en", fifo_read_en, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", {tx, busy, fifo_read_en}, 3'b100);
        end
        chk("idle_no_pop", pop_cnt, 0);

        // 2. Single word.
        enable = 1'b1;
        @(negedge clk);
        pops0 = pop_cnt;
        push(8'h2C, -1);
        wait_frames(1, 200);
        chk("single_pops", pop_cnt - pops0, 1);
        chk("single_empty", fifo_empty, 1);

        // 3. Back-to-back.
        @(negedge clk);
        pops0 = pop_cnt;
        push(8'h55, -1);
        push(8'hAA, 3);
        wait_frames(3, 300);
        chk("b2b_pops", pop_cnt - pops0, 2);

        // 4. Enable gating.
        repeat (5) @(negedge clk);
        enable = 1'b0;
        pops0 = pop_cnt;
        push(8'h41, -1);
        repeat (50) @(negedge clk);
        chk("gated_no_pop", pop_cnt - pops0, 0);
        chk("gated_busy", busy, 0);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 10);
        chk("enable_to_start", n, 3);
        repeat (12) @(negedge clk);
        enable = 1'b0;
        wait_frames(4, 200);
        chk("gated_pops", pop_cnt - pops0, 1);

        // 5. Reset during data bit 3. The popped word is dropped, and the next
        //    word goes out normally.
        repeat (5) @(negedge clk);
        enable = 1'b1;
        pops0 = pop_cnt;
        push(8'h96, -1);
        push(8'h3B, -1);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (17) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("midrst_read_en", fifo_read_en, 0);
        chk("midrst_pops", pop_cnt - pops0, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_frames(5, 200);
        chk("midrst_total_pops", pop_cnt - pops0, 2);
        chk("midrst_sb_empty", exp_q.size(), 0);

`ifdef UART_TX_PARITY_EN
        // 6. Parity frames.
        repeat (5) @(negedge clk);
        push(8'h07, -1);
        push(8'h03, 3);
        wait_frames(7, 300);
`endif

        repeat (5) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
